// File: rtl/ysyx_22050058_mem_arbiter_if.sv
// Downstream memory bus of the IF/LSU memory arbiter.
// master: the arbiter issuing requests; slave: the shared memory/bus port.
interface ysyx_22050058_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W/8-1:0]   mem_wmask_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_W-1:0]     mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/ysyx_22050058_mem_arbiter.sv
// Single-port memory arbiter: IF fetch and LSU load/store share one bus port.
// Fixed priority LSU over IF, one transaction outstanding, flushed fetches
// are completed on the bus but their response is dropped.
// Optional watchdog: define YSYX_22050058_ARB_TIMEOUT_EN to abort a
// transaction after TIMEOUT cycles in REQ/WAIT and raise sticky arb_err_o.
module ysyx_22050058_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req_i,
  input  logic [ADDR_W-1:0]    if_addr_i,
  input  logic                 if_flush_i,
  output logic [31:0]          if_rdata_o,
  output logic                 if_valid_o,
  input  logic                 lsu_req_i,
  input  logic                 lsu_we_i,
  input  logic [ADDR_W-1:0]    lsu_addr_i,
  input  logic [DATA_W-1:0]    lsu_wdata_i,
  input  logic [DATA_W/8-1:0]  lsu_wmask_i,
  output logic [DATA_W-1:0]    lsu_rdata_o,
  output logic                 lsu_valid_o,
  ysyx_22050058_mem_arbiter_if.master mem,
  output logic                 stall_ifreq_o,
  output logic                 stall_lsureq_o,
  output logic                 arb_err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_LSU = 1'b1} owner_t;

  state_t state_r, state_nxt;
  owner_t owner_r, owner_nxt;
  logic   discard_r, discard_nxt;

  logic                 mem_req_r;
  logic                 we_r;
  logic [ADDR_W-1:0]    addr_r;
  logic [DATA_W-1:0]    wdata_r;
  logic [DATA_W/8-1:0]  wmask_r;
  logic                 if_valid_r, lsu_valid_r;
  logic [31:0]          if_rdata_r;
  logic [DATA_W-1:0]    lsu_rdata_r;

  logic load_lsu_s, load_if_s, done_s, timeout_s, drop_s;
  logic deliver_if_s, deliver_lsu_s;

  // Pick the 32-bit instruction word out of a 64-bit beat by address bit 2.
  function automatic logic [31:0] sel_word(input logic [DATA_W-1:0] beat,
                                           input logic hi);
    return hi ? beat[32 +: 32] : beat[0 +: 32];
  endfunction

`ifdef YSYX_22050058_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_r;
  logic             err_r;
  assign timeout_s = (state_r != IDLE) && !done_s && (cnt_r == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and control decode; a requester whose valid_o is high this
  // cycle is still holding its finished request, so it is not re-captured.
  always_comb begin
    state_nxt   = state_r;
    owner_nxt   = owner_r;
    discard_nxt = discard_r;
    load_lsu_s  = 1'b0;
    load_if_s   = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        discard_nxt = 1'b0;
        if (lsu_req_i && !lsu_valid_r) begin
          owner_nxt  = OWN_LSU;
          load_lsu_s = 1'b1;
          state_nxt  = REQ;
        end else if (if_req_i && !if_flush_i && !if_valid_r) begin
          owner_nxt = OWN_IF;
          load_if_s = 1'b1;
          state_nxt = REQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (if_flush_i && owner_r == OWN_IF) discard_nxt = 1'b1;
        else discard_nxt = discard_r;
        if (mem.mem_gnt_i) state_nxt = WAIT;
        else state_nxt = REQ;
      end
      WAIT: begin
        if (if_flush_i && owner_r == OWN_IF) discard_nxt = 1'b1;
        else discard_nxt = discard_r;
        if (mem.mem_rvalid_i) begin
          done_s    = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout_s) state_nxt = IDLE;
    else state_nxt = state_nxt;
  end

  // A flush arriving in the same cycle as the response also kills it.
  assign drop_s        = discard_r || (if_flush_i && owner_r == OWN_IF);
  assign deliver_if_s  = (done_s || timeout_s) && owner_r == OWN_IF && !drop_s;
  assign deliver_lsu_s = (done_s || timeout_s) && owner_r == OWN_LSU;

  // FSM state, owner and discard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      owner_r   <= OWN_IF;
      discard_r <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      owner_r   <= owner_nxt;
      discard_r <= discard_nxt;
    end
  end

  // Bus request and latched payload, stable for the whole REQ phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_r <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      wmask_r   <= '0;
    end else begin
      mem_req_r <= (state_nxt == REQ);
      if (load_lsu_s) begin
        we_r    <= lsu_we_i;
        addr_r  <= lsu_addr_i;
        wdata_r <= lsu_wdata_i;
        wmask_r <= lsu_wmask_i;
      end else if (load_if_s) begin
        we_r    <= 1'b0;
        addr_r  <= if_addr_i;
        wdata_r <= '0;
        wmask_r <= '0;
      end
    end
  end

  // Response capture: one-cycle valid pulses, read data held until next capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_r  <= 1'b0;
      lsu_valid_r <= 1'b0;
      if_rdata_r  <= 32'd0;
      lsu_rdata_r <= '0;
    end else begin
      if_valid_r  <= deliver_if_s;
      lsu_valid_r <= deliver_lsu_s;
      if (deliver_if_s) begin
        if_rdata_r <= timeout_s ? 32'd0 : sel_word(mem.mem_rdata_i, addr_r[2]);
      end
      if (deliver_lsu_s) begin
        lsu_rdata_r <= (timeout_s || we_r) ? '0 : mem.mem_rdata_i;
      end
    end
  end

`ifdef YSYX_22050058_ARB_TIMEOUT_EN
  // Watchdog: count cycles spent in REQ/WAIT; error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      err_r <= 1'b0;
    end else begin
      cnt_r <= (state_r == IDLE || timeout_s) ? '0 : cnt_r + CNT_W'(1);
      if (timeout_s) err_r <= 1'b1;
    end
  end
  assign arb_err_o = err_r;
`else
  assign arb_err_o = 1'b0;
`endif

  assign mem.mem_req_o   = mem_req_r;
  assign mem.mem_we_o    = we_r;
  assign mem.mem_addr_o  = addr_r;
  assign mem.mem_wdata_o = wdata_r;
  assign mem.mem_wmask_o = wmask_r;

  assign if_valid_o  = if_valid_r;
  assign if_rdata_o  = if_rdata_r;
  assign lsu_valid_o = lsu_valid_r;
  assign lsu_rdata_o = lsu_rdata_r;

  assign stall_ifreq_o  = !rst && if_req_i && !if_valid_r;
  assign stall_lsureq_o = !rst && lsu_req_i && !lsu_valid_r;

endmodule

// File: tb/tb_ysyx_22050058_mem_arbiter.sv
// Directed testbench for ysyx_22050058_mem_arbiter.
module tb_ysyx_22050058_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [63:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        lsu_req = 1'b0, lsu_we = 1'b0;
  logic [63:0] lsu_addr = '0, lsu_wdata = '0;
  logic [7:0]  lsu_wmask = '0;
  logic [63:0] lsu_rdata;
  logic        lsu_valid;
  logic        stall_if, stall_lsu, arb_err;
  int          n_checks = 0;
  int          n_fail = 0;

  ysyx_22050058_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  ysyx_22050058_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_rdata_o(if_rdata), .if_valid_o(if_valid),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr),
    .lsu_wdata_i(lsu_wdata), .lsu_wmask_i(lsu_wmask),
    .lsu_rdata_o(lsu_rdata), .lsu_valid_o(lsu_valid),
    .mem(bus.master),
    .stall_ifreq_o(stall_if), .stall_lsureq_o(stall_lsu), .arb_err_o(arb_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; lsu_req = 1'b1;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    step(); step(); #1;
    n_checks++;
    if ({bus.mem_req_o, if_valid, lsu_valid, arb_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl: got %b want 0000", {bus.mem_req_o, if_valid, lsu_valid, arb_err});
    end
    n_checks++;
    if ({stall_if, stall_lsu} !== 2'b00) begin
      n_fail++; $display("FAIL reset_stall: got %b want 00", {stall_if, stall_lsu});
    end
    n_checks++;
    if (if_rdata !== 32'd0 || lsu_rdata !== 64'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h %h want 0 0", if_rdata, lsu_rdata);
    end
    if_req = 1'b0; lsu_req = 1'b0; rst = 1'b0;
    step();
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_addr = 64'h8000_0004; bus.mem_gnt_i = 1'b1; #1;
    n_checks++;
    if (stall_if !== 1'b1) begin n_fail++; $display("FAIL ifrd_stall_N: got %b want 1", stall_if); end
    step();
    n_checks++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 64'h8000_0004 || bus.mem_we_o !== 1'b0 || bus.mem_wmask_o !== 8'h00) begin
      n_fail++; $display("FAIL ifrd_req: got req=%b addr=%h we=%b mask=%h want 1 80000004 0 00",
                         bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o, bus.mem_wmask_o);
    end
    step();
    n_checks++;
    if (bus.mem_req_o !== 1'b0 || stall_if !== 1'b1 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL ifrd_wait: got req=%b stall=%b valid=%b want 0 1 0", bus.mem_req_o, stall_if, if_valid);
    end
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h0123_4567_89AB_CDEF;
    step();
    n_checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h0123_4567 || stall_if !== 1'b0) begin
      n_fail++; $display("FAIL ifrd_resp: got valid=%b data=%h stall=%b want 1 01234567 0", if_valid, if_rdata, stall_if);
    end
    bus.mem_rvalid_i = 1'b0; if_req = 1'b0;
    step();
    n_checks++;
    if (if_valid !== 1'b0 || if_rdata !== 32'h0123_4567 || bus.mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL ifrd_after: got valid=%b data=%h req=%b want 0 01234567 0", if_valid, if_rdata, bus.mem_req_o);
    end
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 64'h8000_0008;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 64'h8000_1000;
    lsu_wdata = 64'h0000_0000_DEAD_BEEF; lsu_wmask = 8'h0F; bus.mem_gnt_i = 1'b1;
    step();
    n_checks++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 64'h8000_1000 ||
        bus.mem_wdata_o !== 64'h0000_0000_DEAD_BEEF || bus.mem_wmask_o !== 8'h0F) begin
      n_fail++; $display("FAIL prio_store: got req=%b we=%b addr=%h wdata=%h mask=%h want 1 1 80001000 deadbeef 0f",
                         bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o);
    end
    step();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    n_checks++;
    if (lsu_valid !== 1'b1 || lsu_rdata !== 64'd0 || if_valid !== 1'b0 || stall_lsu !== 1'b0 || stall_if !== 1'b1) begin
      n_fail++; $display("FAIL prio_ack: got lv=%b ld=%h iv=%b sl=%b si=%b want 1 0 0 0 1",
                         lsu_valid, lsu_rdata, if_valid, stall_lsu, stall_if);
    end
    lsu_req = 1'b0; bus.mem_rvalid_i = 1'b0;
    step();
    n_checks++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 64'h8000_0008 || bus.mem_we_o !== 1'b0 || bus.mem_wmask_o !== 8'h00 || stall_if !== 1'b1) begin
      n_fail++; $display("FAIL prio_if_next: got req=%b addr=%h we=%b mask=%h stall=%b want 1 80000008 0 00 1",
                         bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o, bus.mem_wmask_o, stall_if);
    end
    step();
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h0123_4567_89AB_CDEF;
    step();
    n_checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h89AB_CDEF) begin
      n_fail++; $display("FAIL prio_if_data: got valid=%b data=%h want 1 89abcdef", if_valid, if_rdata);
    end
    if_req = 1'b0; bus.mem_rvalid_i = 1'b0;
    step();
  endtask

  task automatic test_gnt_delay();
    int pulses;
    logic [63:0] ld;
    pulses = 0;
    ld = 64'h1122_3344_5566_7788;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_2000; lsu_wmask = 8'hFF;
    bus.mem_gnt_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      n_checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 64'h8000_2000 || bus.mem_we_o !== 1'b0) begin
        n_fail++; $display("FAIL gdly_hold%0d: got req=%b addr=%h we=%b want 1 80002000 0", c, bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o);
      end
      if (lsu_valid === 1'b1) pulses++;
    end
    bus.mem_gnt_i = 1'b1;
    for (int c = 5; c <= 10; c++) begin
      step();
      if (c == 5) bus.mem_gnt_i = 1'b0;
      if (lsu_valid === 1'b1) pulses++;
      if (c == 5) begin
        n_checks++;
        if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL gdly_dropreq: got %b want 0", bus.mem_req_o); end
      end
      if (c == 8) begin bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = ld; end
      if (c == 9) begin
        n_checks++;
        if (lsu_valid !== 1'b1 || lsu_rdata !== ld) begin
          n_fail++; $display("FAIL gdly_resp: got valid=%b data=%h want 1 %h", lsu_valid, lsu_rdata, ld);
        end
        bus.mem_rvalid_i = 1'b0; lsu_req = 1'b0;
      end
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL gdly_pulses: got %0d want 1", pulses); end
    n_checks++;
    if (lsu_rdata !== ld || arb_err !== 1'b0) begin
      n_fail++; $display("FAIL gdly_hold_data: got data=%h err=%b want %h 0", lsu_rdata, arb_err, ld);
    end
  endtask

`ifdef YSYX_22050058_ARB_TIMEOUT_EN
  task automatic test_timeout();
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_4000; bus.mem_gnt_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      n_checks++;
      if (bus.mem_req_o !== 1'b1 || arb_err !== 1'b0 || lsu_valid !== 1'b0) begin
        n_fail++; $display("FAIL tmo_wait%0d: got req=%b err=%b valid=%b want 1 0 0", c, bus.mem_req_o, arb_err, lsu_valid);
      end
    end
    step();
    n_checks++;
    if (arb_err !== 1'b1 || lsu_valid !== 1'b1 || lsu_rdata !== 64'd0) begin
      n_fail++; $display("FAIL tmo_fire: got err=%b valid=%b data=%h want 1 1 0", arb_err, lsu_valid, lsu_rdata);
    end
    lsu_req = 1'b0;
    step();
    n_checks++;
    if (arb_err !== 1'b1 || lsu_valid !== 1'b0) begin
      n_fail++; $display("FAIL tmo_sticky: got err=%b valid=%b want 1 0", arb_err, lsu_valid);
    end
  endtask
`endif

  task automatic test_flush();
    if_req = 1'b1; if_addr = 64'h8000_0020; bus.mem_gnt_i = 1'b1;
    step();
    step();
    bus.mem_gnt_i = 1'b0; if_flush = 1'b1;
    step();
    if_flush = 1'b0; if_addr = 64'h8000_0010;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h5555_6666_7777_8888;
    step();
    n_checks++;
    if (if_valid !== 1'b0 || bus.mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_drop: got valid=%b req=%b want 0 0", if_valid, bus.mem_req_o);
    end
    bus.mem_rvalid_i = 1'b0; bus.mem_gnt_i = 1'b1;
    step();
    n_checks++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 64'h8000_0010 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_next_req: got req=%b addr=%h valid=%b want 1 80000010 0", bus.mem_req_o, bus.mem_addr_o, if_valid);
    end
    step();
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    n_checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'hCCCC_DDDD) begin
      n_fail++; $display("FAIL flush_next_data: got valid=%b data=%h want 1 ccccdddd", if_valid, if_rdata);
    end
    if_req = 1'b0; bus.mem_rvalid_i = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_3000; bus.mem_gnt_i = 1'b1;
    step();
    step();
    rst = 1'b1; bus.mem_gnt_i = 1'b0;
    step();
    n_checks++;
    if (bus.mem_req_o !== 1'b0 || lsu_valid !== 1'b0 || stall_lsu !== 1'b0 || arb_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid: got req=%b valid=%b stall=%b err=%b want 0 0 0 0", bus.mem_req_o, lsu_valid, stall_lsu, arb_err);
    end
    rst = 1'b0; lsu_req = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h9999_9999_9999_9999;
    step();
    bus.mem_rvalid_i = 1'b0;
    step();
    n_checks++;
    if (lsu_valid !== 1'b0 || if_valid !== 1'b0 || bus.mem_req_o !== 1'b0 || lsu_rdata !== 64'd0) begin
      n_fail++; $display("FAIL rstmid_stray: got lv=%b iv=%b req=%b data=%h want 0 0 0 0", lsu_valid, if_valid, bus.mem_req_o, lsu_rdata);
    end
  endtask

  initial begin
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    test_reset();
    test_if_read();
    test_priority();
    test_gnt_delay();
`ifdef YSYX_22050058_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
